reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb_pkg.sv | 16 +
 rtl/reg_file_sb_scoreboard.sv | 63 ++++++
 rtl/reg_file_sb.sv | 92 +++++++++
 tb/tb_reg_file_sb.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the scoreboarded register file: default sizes,
// address-width derivation and fixed register indices.
package reg_file_sb_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NREGS_MIN = 2;
    localparam int NREGS_MAX = 64;
    localparam int REG_ZERO  = 0;

    // Address width for a register count; never narrower than one bit.
    function automatic int addr_width(input int nregs);
        return (nregs <= 1) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered
// population counter. Flush beats alloc, alloc beats a same-address write.
module reg_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int ZERO_REG = 1,
    parameter int AW       = addr_width(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_alloc_en,
    input  logic [AW-1:0]    i_alloc_addr,
    input  logic             i_wen,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic             i_flush,
    output logic [NREGS-1:0] o_busy,
    output logic [AW:0]      o_busy_count
);

    localparam logic [NREGS-1:0] ONE   = NREGS'(1);
    // Register 0 can never be allocated when it is hardwired to zero.
    localparam logic [NREGS-1:0] ZMASK = (ZERO_REG != 0) ? ONE : '0;

    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_count;
    logic [NREGS-1:0] w_set_mask;
    logic [NREGS-1:0] w_clr_mask;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      w_count_nxt;
    logic             w_inc;
    logic             w_dec;

    // Next busy vector and counter delta; out-of-range addresses shift off the end.
    always_comb begin
        w_set_mask = i_alloc_en ? ((ONE << i_alloc_addr) & ~ZMASK) : '0;
        w_clr_mask = i_wen ? (ONE << i_wr_addr) : '0;
        w_inc      = |(w_set_mask & ~r_busy);
        w_dec      = |(w_clr_mask & r_busy & ~w_set_mask);
        if (i_flush) begin
            w_busy_nxt  = '0;
            w_count_nxt = '0;
        end else begin
            w_busy_nxt  = (r_busy & ~w_clr_mask) | w_set_mask;
            w_count_nxt = r_count + (AW+1)'(w_inc) - (AW+1)'(w_dec);
        end
    end

    // Busy state and counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign o_busy       = r_busy;
    assign o_busy_count = r_count;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, write-first bypass and
// a pending-write scoreboard used for operand readiness.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int ZERO_REG = 1,
    parameter int AW       = addr_width(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   io_rs1_addr,
    input  logic [AW-1:0]   io_rs2_addr,
    output logic [XLEN-1:0] io_rs1_data,
    output logic [XLEN-1:0] io_rs2_data,
    output logic            io_rs1_busy,
    output logic            io_rs2_busy,
    input  logic            io_wen,
    input  logic [AW-1:0]   io_wr_addr,
    input  logic [XLEN-1:0] io_wr_data,
    input  logic            io_alloc_en,
    input  logic [AW-1:0]   io_alloc_addr,
    input  logic            io_flush,
    output logic [AW:0]     io_busy_count
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] w_busy;
    logic             w_rs1_ok;
    logic             w_rs2_ok;
    logic             w_wr_ok;
    logic             w_rs1_hit;
    logic             w_rs2_hit;

    // An address is live if it is in range and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign w_rs1_ok  = addr_ok(io_rs1_addr);
    assign w_rs2_ok  = addr_ok(io_rs2_addr);
    assign w_wr_ok   = addr_ok(io_wr_addr);
    assign w_rs1_hit = io_wen && (io_wr_addr == io_rs1_addr);
    assign w_rs2_hit = io_wen && (io_wr_addr == io_rs2_addr);

    // Storage update; dead addresses are never written.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (io_wen && w_wr_ok) begin
            r_regs[io_wr_addr] <= io_wr_data;
        end
    end

    // Read ports: write-first bypass, and an in-flight writeback counts as ready.
    always_comb begin
        io_rs1_data = '0;
        io_rs2_data = '0;
        io_rs1_busy = 1'b0;
        io_rs2_busy = 1'b0;
        if (w_rs1_ok) begin
            io_rs1_data = w_rs1_hit ? io_wr_data : r_regs[io_rs1_addr];
            io_rs1_busy = w_busy[io_rs1_addr] && !w_rs1_hit;
        end
        if (w_rs2_ok) begin
            io_rs2_data = w_rs2_hit ? io_wr_data : r_regs[io_rs2_addr];
            io_rs2_busy = w_busy[io_rs2_addr] && !w_rs2_hit;
        end
    end

    reg_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clock        (clock),
        .reset        (reset),
        .i_alloc_en   (io_alloc_en),
        .i_alloc_addr (io_alloc_addr),
        .i_wen        (io_wen),
        .i_wr_addr    (io_wr_addr),
        .i_flush      (io_flush),
        .o_busy       (w_busy),
        .o_busy_count (io_busy_count)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: three instances (default 32x32, 16 regs x 64 bits,
// 20 regs x 16 bits without a zero register) share one stimulus stream and
// are compared against an array-based reference model.
module tb_reg_file_sb;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  s_rs1, s_rs2, s_wa, s_aa;
    logic [63:0] s_wd;
    logic        s_wen, s_alloc, s_flush;

    logic [31:0] a_rs1_data, a_rs2_data;
    logic        a_rs1_busy, a_rs2_busy;
    logic [5:0]  a_cnt;
    logic [63:0] b_rs1_data, b_rs2_data;
    logic        b_rs1_busy, b_rs2_busy;
    logic [4:0]  b_cnt;
    logic [15:0] c_rs1_data, c_rs2_data;
    logic        c_rs1_busy, c_rs2_busy;
    logic [5:0]  c_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    logic [63:0] m_regs [3][64];
    bit          m_busy [3][64];

    always #5 clock = ~clock;

    reg_file_sb u_a (
        .clock(clock), .reset(reset),
        .io_rs1_addr(s_rs1), .io_rs2_addr(s_rs2),
        .io_rs1_data(a_rs1_data), .io_rs2_data(a_rs2_data),
        .io_rs1_busy(a_rs1_busy), .io_rs2_busy(a_rs2_busy),
        .io_wen(s_wen), .io_wr_addr(s_wa), .io_wr_data(s_wd[31:0]),
        .io_alloc_en(s_alloc), .io_alloc_addr(s_aa),
        .io_flush(s_flush), .io_busy_count(a_cnt)
    );

    reg_file_sb #(.XLEN(64), .NREGS(16)) u_b (
        .clock(clock), .reset(reset),
        .io_rs1_addr(s_rs1[3:0]), .io_rs2_addr(s_rs2[3:0]),
        .io_rs1_data(b_rs1_data), .io_rs2_data(b_rs2_data),
        .io_rs1_busy(b_rs1_busy), .io_rs2_busy(b_rs2_busy),
        .io_wen(s_wen), .io_wr_addr(s_wa[3:0]), .io_wr_data(s_wd),
        .io_alloc_en(s_alloc), .io_alloc_addr(s_aa[3:0]),
        .io_flush(s_flush), .io_busy_count(b_cnt)
    );

    reg_file_sb #(.XLEN(16), .NREGS(20), .ZERO_REG(0)) u_c (
        .clock(clock), .reset(reset),
        .io_rs1_addr(s_rs1), .io_rs2_addr(s_rs2),
        .io_rs1_data(c_rs1_data), .io_rs2_data(c_rs2_data),
        .io_rs1_busy(c_rs1_busy), .io_rs2_busy(c_rs2_busy),
        .io_wen(s_wen), .io_wr_addr(s_wa), .io_wr_data(s_wd[15:0]),
        .io_alloc_en(s_alloc), .io_alloc_addr(s_aa),
        .io_flush(s_flush), .io_busy_count(c_cnt)
    );

    function automatic int nr(input int d);
        return (d == 0) ? 32 : (d == 1) ? 16 : 20;
    endfunction

    function automatic int zr(input int d);
        return (d == 2) ? 0 : 1;
    endfunction

    function automatic int am(input int d, input int a);
        int w;
        w = (d == 1) ? 4 : 5;
        return a & ((1 << w) - 1);
    endfunction

    function automatic logic [63:0] xm(input int d);
        return (d == 0) ? 64'h0000_0000_FFFF_FFFF :
               (d == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
    endfunction

    function automatic bit live(input int d, input int a);
        return (a < nr(d)) && !((zr(d) == 1) && (a == 0));
    endfunction

    function automatic logic [63:0] exp_data(input int d, input int ra_in);
        int ra, wa;
        ra = am(d, ra_in);
        wa = am(d, int'(s_wa));
        if (!live(d, ra)) return 64'd0;
        if (s_wen && wa == ra) return s_wd & xm(d);
        return m_regs[d][ra];
    endfunction

    function automatic logic [63:0] exp_busy(input int d, input int ra_in);
        int ra, wa;
        ra = am(d, ra_in);
        wa = am(d, int'(s_wa));
        if (!live(d, ra)) return 64'd0;
        if (s_wen && wa == ra) return 64'd0;
        return m_busy[d][ra] ? 64'd1 : 64'd0;
    endfunction

    function automatic logic [63:0] exp_count(input int d);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) if (m_busy[d][i]) n++;
        return 64'(n);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 64; i++) begin
                m_regs[d][i] = 64'd0;
                m_busy[d][i] = 1'b0;
            end
    endtask

    task automatic model_update();
        int wa, aa;
        for (int d = 0; d < 3; d++) begin
            wa = am(d, int'(s_wa));
            aa = am(d, int'(s_aa));
            if (s_wen && live(d, wa)) m_regs[d][wa] = s_wd & xm(d);
            if (s_flush) begin
                for (int i = 0; i < 64; i++) m_busy[d][i] = 1'b0;
            end else begin
                if (s_wen && live(d, wa)) m_busy[d][wa] = 1'b0;
                if (s_alloc && live(d, aa)) m_busy[d][aa] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("A.rs1_data", 64'(a_rs1_data), exp_data(0, int'(s_rs1)));
        chk("A.rs2_data", 64'(a_rs2_data), exp_data(0, int'(s_rs2)));
        chk("A.rs1_busy", 64'(a_rs1_busy), exp_busy(0, int'(s_rs1)));
        chk("A.rs2_busy", 64'(a_rs2_busy), exp_busy(0, int'(s_rs2)));
        chk("A.count",    64'(a_cnt),      exp_count(0));
        chk("B.rs1_data", b_rs1_data,      exp_data(1, int'(s_rs1)));
        chk("B.rs2_data", b_rs2_data,      exp_data(1, int'(s_rs2)));
        chk("B.rs1_busy", 64'(b_rs1_busy), exp_busy(1, int'(s_rs1)));
        chk("B.rs2_busy", 64'(b_rs2_busy), exp_busy(1, int'(s_rs2)));
        chk("B.count",    64'(b_cnt),      exp_count(1));
        chk("C.rs1_data", 64'(c_rs1_data), exp_data(2, int'(s_rs1)));
        chk("C.rs2_data", 64'(c_rs2_data), exp_data(2, int'(s_rs2)));
        chk("C.rs1_busy", 64'(c_rs1_busy), exp_busy(2, int'(s_rs1)));
        chk("C.rs2_busy", 64'(c_rs2_busy), exp_busy(2, int'(s_rs2)));
        chk("C.count",    64'(c_cnt),      exp_count(2));
    endtask

    task automatic sample();
        @(negedge clock);
        check_all();
    endtask

    task automatic advance();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        s_wen = 1'b0; s_alloc = 1'b0; s_flush = 1'b0;
        s_wa = 5'd0; s_aa = 5'd0; s_wd = 64'd0;
    endtask

    initial begin
        reset = 1'b0;
        s_rs1 = 5'd0; s_rs2 = 5'd0;
        idle_inputs();
        model_reset();
        sample();
        reset = 1'b1;
        advance();

        // Every address reads zero and not busy after reset.
        for (int a = 0; a < 32; a++) begin
            s_rs1 = 5'(a);
            s_rs2 = 5'(31 - a);
            sample();
            chk("rst_rd_data", 64'(a_rs1_data), 64'd0);
            chk("rst_rd_busy", 64'(a_rs1_busy), 64'd0);
            advance();
        end

        // Write-first bypass on r5, then the stored value.
        s_rs1 = 5'd5; s_wen = 1'b1; s_wa = 5'd5; s_wd = 64'h0000_0000_DEAD_BEEF;
        sample();
        chk("bypass_r5", 64'(a_rs1_data), 64'hDEAD_BEEF);
        advance();
        idle_inputs();
        sample();
        chk("stored_r5", 64'(a_rs1_data), 64'hDEAD_BEEF);
        advance();

        // r0 stays zero during and after a write.
        s_rs2 = 5'd0; s_wen = 1'b1; s_wa = 5'd0; s_wd = 64'h1234;
        sample();
        chk("r0_during", 64'(a_rs2_data), 64'd0);
        advance();
        idle_inputs();
        sample();
        chk("r0_after", 64'(a_rs2_data), 64'd0);
        advance();

        // Alloc 3, 7, 9 then write back 7.
        s_alloc = 1'b1;
        s_aa = 5'd3; sample(); advance();
        s_aa = 5'd7; sample(); advance();
        s_aa = 5'd9; sample(); advance();
        idle_inputs();
        s_rs1 = 5'd7;
        sample();
        chk("alloc3_count", 64'(a_cnt), 64'd3);
        chk("alloc3_busy7", 64'(a_rs1_busy), 64'd1);
        advance();
        s_wen = 1'b1; s_wa = 5'd7; s_wd = 64'h77;
        sample();
        chk("wb7_busy", 64'(a_rs1_busy), 64'd0);
        advance();
        idle_inputs();
        sample();
        chk("wb7_count", 64'(a_cnt), 64'd2);
        advance();

        // Alloc and write r4 together: data lands, busy stays set.
        s_alloc = 1'b1; s_aa = 5'd4; s_wen = 1'b1; s_wa = 5'd4; s_wd = 64'hA5;
        s_rs1 = 5'd4;
        sample();
        advance();
        idle_inputs();
        sample();
        chk("same4_data", 64'(a_rs1_data), 64'hA5);
        chk("same4_busy", 64'(a_rs1_busy), 64'd1);
        chk("same4_count", 64'(a_cnt), 64'd3);
        advance();

        // Five more allocs, then flush beats a same-cycle alloc, on A and B.
        s_alloc = 1'b1;
        for (int a = 10; a < 15; a++) begin
            s_aa = 5'(a);
            sample();
            advance();
        end
        idle_inputs();
        sample();
        chk("pre_flush_A", 64'(a_cnt), 64'd8);
        chk("pre_flush_B", 64'(b_cnt), 64'd8);
        advance();
        s_flush = 1'b1; s_alloc = 1'b1; s_aa = 5'd2;
        sample();
        advance();
        idle_inputs();
        s_rs1 = 5'd2;
        sample();
        chk("flush_A_count", 64'(a_cnt), 64'd0);
        chk("flush_A_busy2", 64'(a_rs1_busy), 64'd0);
        chk("flush_B_count", 64'(b_cnt), 64'd0);
        chk("flush_B_busy2", 64'(b_rs1_busy), 64'd0);
        advance();

        // Randomized traffic with address collisions encouraged.
        for (int n = 0; n < 3000; n++) begin
            s_rs1   = 5'($urandom_range(0, 31));
            s_rs2   = 5'($urandom_range(0, 31));
            s_wa    = 5'($urandom_range(0, 31));
            s_aa    = 5'($urandom_range(0, 31));
            s_wd    = {$urandom, $urandom};
            s_wen   = 1'($urandom_range(0, 1));
            s_alloc = 1'($urandom_range(0, 1));
            s_flush = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 3) == 0) s_rs1 = s_wa;
            if ($urandom_range(0, 3) == 0) s_aa = s_wa;
            if ($urandom_range(0, 7) == 0) s_rs2 = 5'd0;
            sample();
            advance();
        end

        // Reset arriving in the middle of a write discards it.
        idle_inputs();
        s_wen = 1'b1; s_wa = 5'd9; s_wd = 64'hCAFE_F00D_1357_2468;
        s_alloc = 1'b1; s_aa = 5'd6;
        sample();
        advance();
        s_alloc = 1'b0; s_wd = 64'h1111_2222_3333_4444;
        s_rs1 = 5'd9; s_rs2 = 5'd6;
        #2;
        reset = 1'b0;
        #1;
        chk("async_count", 64'(a_cnt), 64'd0);
        chk("async_r6", 64'(a_rs2_data), 64'd0);
        chk("async_busy6", 64'(a_rs2_busy), 64'd0);
        @(posedge clock);
        #1;
        s_wen = 1'b0;
        model_reset();
        sample();
        chk("midwr_r9", 64'(a_rs1_data), 64'd0);
        reset = 1'b1;
        advance();
        sample();
        advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
